// File: rtl/hazard_unit.sv
// Hazard unit for the pipelined RV32I core: mirrors rd/rs IDs through E/M/W and returns stall, flush and bypass controls.
// Defining HAZARD_STATS_EN adds saturating load-use stall and control-flush counters.

module fwdSel #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rsE,
  input  logic [ADDR_W-1:0] rdM,
  input  logic              regWriteM,
  input  logic [ADDR_W-1:0] rdW,
  input  logic              regWriteW,
  output logic [1:0]        fwd
);
  // The younger writer in M must win over W; x0 is hardwired and never bypassed.
  always_comb begin
    fwd = 2'b00;
    if (regWriteM && rdM != '0 && rdM == rsE)      fwd = 2'b10;
    else if (regWriteW && rdW != '0 && rdW == rsE) fwd = 2'b01;
  end
endmodule

module hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  input  logic [ADDR_W-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              ValidD,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);
  localparam logic [1:0] SRC_LOAD = 2'b01;

  typedef struct packed {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              regWrite;
    logic [1:0]        resultSrc;
  } exStage_t;

  // Past E only the writer identity matters for bypassing.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              regWrite;
  } wbStage_t;

  exStage_t stE, dIn;
  wbStage_t stM, stW;
  logic     lwStall;

  assign dIn = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, regWrite: RegWriteD & ValidD,
                 resultSrc: ResultSrcD};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stE <= '0;
      stM <= '0;
      stW <= '0;
    end else begin
      stW <= stM;
      stM <= '{rd: stE.rd, regWrite: stE.regWrite};
      stE <= FlushE ? '0 : dIn;
    end
  end

  assign lwStall = (stE.resultSrc == SRC_LOAD) && stE.regWrite && (stE.rd != '0) &&
                   ((stE.rd == Rs1D) || (stE.rd == Rs2D));

  // PCSrcE is a raw input, so gate with reset to keep every output low while in reset.
  assign StallF = lwStall & ~PCSrcE & reset;
  assign StallD = lwStall & ~PCSrcE & reset;
  assign FlushD = PCSrcE & reset;
  assign FlushE = (lwStall | PCSrcE) & reset;

  logic [1:0][ADDR_W-1:0] rsE;
  logic [1:0][1:0]        fwd;

  assign rsE = {stE.rs2, stE.rs1};

  for (genvar g = 0; g < 2; g++) begin : gFwd
    fwdSel #(.ADDR_W(ADDR_W)) uFwd (
      .rsE      (rsE[g]),
      .rdM      (stM.rd),
      .regWriteM(stM.regWrite),
      .rdW      (stW.rd),
      .regWriteW(stW.regWrite),
      .fwd      (fwd[g])
    );
  end

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (StallD && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
      if (PCSrcE && flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign StallCount = stallCnt;
  assign FlushCount = flushCnt;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: an instruction-level model of E/M/W predicts each cycle's controls,
// a negedge monitor pops and compares. Directed test-plan sequences followed by random traffic.
module tb_hazard_unit;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic clk = 0, reset = 0;
  logic [ADDR_W-1:0] Rs1D = '0, Rs2D = '0, RdD = '0;
  logic RegWriteD = 0, ValidD = 0, PCSrcE = 0;
  logic [1:0] ResultSrcD = '0;
  logic StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCount, FlushCount;

  hazard_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .ValidD(ValidD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  // Model: an in-flight instruction record per stage (0=E, 1=M, 2=W).
  typedef struct {
    int rd, rs1, rs2;
    bit wr, isLoad;
  } instr_t;

  typedef struct packed {
    logic stallF, stallD, flushD, flushE;
    logic [1:0] fa, fb;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  instr_t pipe[3];
  int     mStall, mFlush;
  exp_t   expQ[$];
  int     checks = 0, errors = 0;

  function automatic instr_t bubble();
    instr_t b;
    b.rd = 0; b.rs1 = 0; b.rs2 = 0; b.wr = 0; b.isLoad = 0;
    return b;
  endfunction

  function automatic void modelReset();
    for (int s = 0; s < 3; s++) pipe[s] = bubble();
    mStall = 0;
    mFlush = 0;
  endfunction

  // Newest preceding writer of rs wins: M (distance 1) before W (distance 2).
  function automatic logic [1:0] fwdOf(int rs);
    for (int s = 1; s <= 2; s++)
      if (pipe[s].wr && pipe[s].rd != 0 && pipe[s].rd == rs)
        return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(int rs1, int rs2, int rd, bit rw, int rsrc, bit vld, bit pc);
    exp_t e;
    bit   lw;
    @(posedge clk); #1;
    Rs1D = ADDR_W'(rs1); Rs2D = ADDR_W'(rs2); RdD = ADDR_W'(rd);
    RegWriteD = rw; ResultSrcD = 2'(rsrc); ValidD = vld; PCSrcE = pc;
    lw = pipe[0].isLoad && pipe[0].wr && pipe[0].rd != 0 &&
         (pipe[0].rd == rs1 || pipe[0].rd == rs2);
    e.stallF = lw && !pc;
    e.stallD = lw && !pc;
    e.flushD = pc;
    e.flushE = lw || pc;
    e.fa = fwdOf(pipe[0].rs1);
    e.fb = fwdOf(pipe[0].rs2);
`ifdef HAZARD_STATS_EN
    e.sc = CNT_W'(mStall);
    e.fc = CNT_W'(mFlush);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    expQ.push_back(e);
    if (e.stallD) mStall++;
    if (pc) mFlush++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (e.flushE) pipe[0] = bubble();
    else begin
      pipe[0].rd = rd; pipe[0].rs1 = rs1; pipe[0].rs2 = rs2;
      pipe[0].wr = rw && vld; pipe[0].isLoad = (rsrc == 1);
    end
  endtask

  task automatic checkAllZero(string tag);
    chk({tag, "_StallF"}, StallF, 0);
    chk({tag, "_StallD"}, StallD, 0);
    chk({tag, "_FlushD"}, FlushD, 0);
    chk({tag, "_FlushE"}, FlushE, 0);
    chk({tag, "_FwdA"}, ForwardAE, 0);
    chk({tag, "_FwdB"}, ForwardBE, 0);
    chk({tag, "_StallCount"}, StallCount, 0);
    chk({tag, "_FlushCount"}, FlushCount, 0);
  endtask

  // Reset asserted between edges, after the monitor has consumed this cycle's expectation.
  task automatic midReset();
    @(negedge clk); #1;
    reset = 0;
    #1;
    checkAllZero("midReset");
    modelReset();
    #1 reset = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("StallF", StallF, e.stallF);
        chk("StallD", StallD, e.stallD);
        chk("FlushD", FlushD, e.flushD);
        chk("FlushE", FlushE, e.flushE);
        chk("ForwardAE", ForwardAE, e.fa);
        chk("ForwardBE", ForwardBE, e.fb);
        chk("StallCount", StallCount, e.sc);
        chk("FlushCount", FlushCount, e.fc);
      end
    end
  end

  initial begin : stim
    modelReset();
    #2 checkAllZero("reset");
    #10 reset = 1;

    // ALU RAW: add x5, then sub reading x5 -> ForwardAE=10 with add in M
    drive(1, 2, 5, 1, 0, 1, 0);
    drive(5, 3, 6, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // W hit: producer x7, consumer two behind
    drive(2, 3, 7, 1, 0, 1, 0);
    drive(1, 2, 8, 1, 0, 1, 0);
    drive(0, 7, 9, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // M priority: x7 in M and W
    drive(0, 0, 7, 1, 0, 1, 0);
    drive(0, 0, 7, 1, 0, 1, 0);
    drive(0, 7, 1, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // Load-use: lw x6, dependent stalls one cycle then gets ForwardAE=01
    drive(0, 0, 6, 1, 1, 1, 0);
    drive(6, 0, 10, 1, 0, 1, 0);
    drive(6, 0, 10, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // x0 writers: no stall, no forward
    drive(0, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 2, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 3, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // ValidD=0 writer of x11 must not forward
    drive(0, 0, 11, 1, 0, 0, 0);
    drive(11, 11, 12, 1, 0, 1, 0);
    drive(11, 11, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // Branch alone, then branch with a simultaneous load-use condition
    drive(1, 2, 4, 1, 0, 1, 1);
    drive(0, 0, 3, 1, 1, 1, 0);
    drive(3, 0, 4, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    // Two more load-use stalls (total 3 stalls, 2 flushes)
    drive(0, 0, 8, 1, 1, 1, 0);
    drive(0, 8, 9, 1, 0, 1, 0);
    drive(0, 8, 9, 1, 0, 1, 0);
    drive(0, 0, 12, 1, 1, 1, 0);
    drive(12, 12, 13, 1, 0, 1, 0);
    drive(12, 12, 13, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // Reset during a load-use stall, then readers with no writers in flight
    drive(0, 0, 4, 1, 1, 1, 0);
    drive(4, 0, 5, 1, 0, 1, 0);
    midReset();
    drive(4, 4, 0, 0, 0, 1, 0);
    drive(4, 4, 0, 0, 0, 1, 0);
    drive(5, 4, 0, 0, 0, 1, 0);

    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);

    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    chk("drain", expQ.size(), 0);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
